// File: rtl/l1d_resp_pkg.sv
// Shared types and helpers for the L1 data-cache memory responder.
package l1d_resp_pkg;

  localparam int CACHE_TYPE_BITS = 2;
  localparam logic [1:0] BYTE  = 2'b00;
  localparam logic [1:0] HWORD = 2'b01;
  localparam logic [1:0] WORD  = 2'b10;
  localparam int LINE_BEATS = 4;

  typedef enum logic [2:0] {
    IDLE,
    RLAT,
    RBEAT,
    WLAT,
    WACK
  } resp_state_e;

  function automatic logic [3:0] strb_f(input logic [1:0] typ, input logic [1:0] addr);
    logic [3:0] s;
    case (typ)
      BYTE:    s = 4'b0001 << addr;
      HWORD:   s = addr[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic in_range_f(input logic [31:0] addr, input logic [31:0] base,
                                      input logic [31:0] bytes);
    logic [31:0] off;
    off = addr - base;
    return (addr >= base) && (off < bytes);
  endfunction

endpackage

// File: rtl/l1d_mem_responder_sram.sv
// Single-port word SRAM with byte write enables and a registered read port.
module resp_sram #(
  parameter int WORDS = 16384,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end else if (en) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/l1d_mem_responder.sv
// Memory-side responder for the L1 D-cache port: line-fill bursts, single-beat
// reads and byte/half/word writes served from a local SRAM with fixed latency.
module l1d_mem_responder
  import l1d_resp_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 16384,
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned WR_LAT    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       D_rreq,
  input  logic                       D_wreq,
  input  logic [31:0]                D_addr,
  input  logic                       D_write,
  input  logic [31:0]                D_in,
  input  logic [CACHE_TYPE_BITS-1:0] D_type,
  input  logic                       arlenone_i,
  output logic [31:0]                D_out,
  output logic                       D_wait,
  output logic                       err_o,
  output resp_state_e                state_o
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);
  localparam logic [3:0] RD_LAT0 = 4'((RD_LAT > 1) ? RD_LAT - 2 : 0);
  localparam logic [3:0] WR_LAT0 = 4'((WR_LAT > 1) ? WR_LAT - 2 : 0);

  // Handshake: a request is taken only in IDLE on a rising edge of
  // (D_rreq|D_wreq); every read beat and write ack is one cycle with D_wait=0.

  resp_state_e   state_q, state_d;
  logic          req_q;
  logic [1:0]    cnt_q, cnt_d;
  logic [3:0]    lat_q, lat_d;
  logic [AW-1:0] widx_q, widx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    strb_q, strb_d;
  logic          single_q, single_d;
  logic          oor_q, oor_d;
  logic [31:0]   dout_q, dout_d;

  logic          req, accept, acc_wr;
  logic [31:0]   acc_base, acc_off;
  logic [AW-1:0] acc_widx, rd_idx, sram_addr;
  logic          sram_en, sram_we;
  logic [31:0]   sram_rdata, beat_data;

  assign req    = D_rreq | D_wreq;
  assign accept = (state_q == IDLE) && req && !req_q;
  assign acc_wr = D_wreq & D_write;

  // Writes and single reads address one word; bursts address the aligned line.
  assign acc_base = (acc_wr || arlenone_i) ? {D_addr[31:2], 2'b00} : {D_addr[31:4], 4'b0000};
  assign acc_off  = acc_base - BASE_ADDR;
  assign acc_widx = AW'(acc_off >> 2);

  always_comb begin
    case (state_q)
      RBEAT:   rd_idx = {widx_q[AW-1:2], cnt_q + 2'd1};
      RLAT:    rd_idx = widx_q;
      default: rd_idx = acc_widx;
    endcase
  end

  assign sram_en   = (state_q == IDLE) || (state_q == RLAT) || (state_q == RBEAT);
  assign sram_we   = (state_q == WACK) && !oor_q;
  assign sram_addr = (state_q == WACK) ? widx_q : rd_idx;

  resp_sram #(
    .WORDS(MEM_WORDS),
    .AW   (AW)
  ) u_sram (
    .clk  (clk),
    .en   (sram_en),
    .we   (sram_we),
    .be   (strb_q),
    .addr (sram_addr),
    .wdata(wdata_q),
    .rdata(sram_rdata)
  );

  assign beat_data = oor_q ? 32'h0 : sram_rdata;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lat_d    = lat_q;
    widx_d   = widx_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    single_d = single_q;
    oor_d    = oor_q;
    dout_d   = dout_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          widx_d   = acc_widx;
          wdata_d  = D_in;
          strb_d   = strb_f(D_type[1:0], D_addr[1:0]);
          single_d = arlenone_i;
          oor_d    = !in_range_f(acc_base, BASE_ADDR, MEM_BYTES);
          cnt_d    = 2'd0;
          if (acc_wr) begin
            lat_d   = WR_LAT0;
            state_d = (WR_LAT > 1) ? WLAT : WACK;
          end else begin
            lat_d   = RD_LAT0;
            state_d = (RD_LAT > 1) ? RLAT : RBEAT;
          end
        end
      end
      RLAT: begin
        if (lat_q == 4'd0) state_d = RBEAT;
        else lat_d = lat_q - 4'd1;
      end
      RBEAT: begin
        dout_d = beat_data;
        if (single_q || (cnt_q == 2'(LINE_BEATS - 1))) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      WLAT: begin
        if (lat_q == 4'd0) state_d = WACK;
        else lat_d = lat_q - 4'd1;
      end
      WACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      cnt_q    <= 2'd0;
      lat_q    <= 4'd0;
      widx_q   <= '0;
      wdata_q  <= 32'h0;
      strb_q   <= 4'h0;
      single_q <= 1'b0;
      oor_q    <= 1'b0;
      dout_q   <= 32'h0;
    end else begin
      state_q  <= state_d;
      req_q    <= req;
      cnt_q    <= cnt_d;
      lat_q    <= lat_d;
      widx_q   <= widx_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      single_q <= single_d;
      oor_q    <= oor_d;
      dout_q   <= dout_d;
    end
  end

  assign D_out   = (state_q == RBEAT) ? beat_data : dout_q;
  assign D_wait  = !((state_q == RBEAT) || (state_q == WACK));
  assign err_o   = !D_wait && oor_q;
  assign state_o = state_q;

endmodule

// File: doc/l1d_mem_responder.md
Name: l1d_mem_responder

Overview:
Memory-side responder for the L1 data cache request interface (D_rreq/D_wreq/D_addr/D_type/D_in → D_out/D_wait). It services 4-word line-fill bursts, single-beat uncacheable reads (arlenone) and byte/half/word writes. It serves them from a local byte-enabled word SRAM with configurable latency. It stands in for the memory/bus side in block-level cache integration and bring-up.

Parameters:
MEM_WORDS, 16384, SRAM depth in 32-bit words (64 KiB window)
BASE_ADDR, 32'h0001_0000, byte address of word 0; accesses outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS) are out-of-range
RD_LAT, 2, cycles from request acceptance to first read beat (legal 1..15)
WR_LAT, 1, cycles from request acceptance to write ack (legal 1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
D_rreq  in  1  read request
D_wreq  in  1  write request
D_addr  in  32  byte address; bursts use D_addr[31:4]
D_write  in  1  write qualifier; must be 1 with D_wreq, ignored otherwise
D_in  in  32  write data, already byte-lane aligned
D_type  in  `CACHE_TYPE_BITS  access size; [1:0] uses `BYTE/`HWORD/`WORD
arlenone_i  in  1  1 = single-beat read, 0 = 4-beat line burst
D_out  out  32  read data, valid only while D_wait=0 on a read
D_wait  out  1  0 for exactly one cycle per read beat or write ack, else 1
err_o  out  1  one-cycle pulse with the D_wait=0 beat/ack of an out-of-range access

Behaviour:
- Reset (sync, active-high): state IDLE, D_wait=1, D_out=0, err_o=0, beat cnt=0, req_q=0. SRAM contents are not cleared. Reset mid-transaction aborts it; an uncommitted write is dropped.
- req_q is a register of (D_rreq|D_wreq). A request is accepted only in IDLE on a rising edge: req high and req_q low. This prevents re-triggering while the cache holds D_rreq after its last beat.
- If D_rreq and D_wreq are both high at acceptance, the write wins. Requests outside IDLE are ignored.
- At acceptance (cycle T), latch addr, D_in, D_type[1:0], arlenone_i and out-of-range flag.
- States:
  - IDLE: go to WLAT on an accepted write, or RLAT on an accepted read.
  - RLAT: count RD_LAT-1 cycles, issuing the SRAM read one cycle before each beat. Then go to RBEAT.
  - RBEAT: D_wait=0 and D_out=word for one cycle per beat. First beat is at T+RD_LAT; burst beats follow back-to-back (T+RD_LAT..T+RD_LAT+3). Burst word index = cnt (0..3) from the line-aligned address, with no wrap to the critical word. Single-beat reads use word addr[31:2]. Return to IDLE after the last beat.
  - WLAT: wait WR_LAT-1 cycles, then go to WACK.
  - WACK: D_wait=0 for one cycle; the SRAM write commits at this clock edge. Return to IDLE.
- Write strobes:
  - BYTE: 1<<addr[1:0].
  - HWORD: addr[1] ? 4'b1100 : 4'b0011; addr[0] is ignored.
  - WORD: 4'b1111; addr[1:0] is ignored.
- D_out holds its last value when D_wait=1. It is not updated by writes.
- Out-of-range reads return 32'h0. Out-of-range writes are dropped. Either asserts err_o with the D_wait=0 cycle; the handshake timing is unchanged.
- A burst is range-checked on its aligned line base. A line straddling the top boundary cannot occur because MEM_WORDS is a multiple of 4.
- Read-after-write: a read accepted the cycle after WACK returns the new data, since the SRAM write has committed.
- cnt is 2 bits and wraps only by the state exit; it never exceeds 3.

Decomposition:
- Package l1d_resp_pkg:
  - state enum {IDLE, RLAT, RBEAT, WLAT, WACK}
  - LINE_BEATS=4
  - function strb_f(type[1:0], addr[1:0]) returning 4-bit strobes
  - function in_range_f
- Sub-module resp_sram: word-addressed, 1-cycle registered read, 4-bit byte write enable, single port (read and write never overlap in the same cycle).

Test Plan:
1. Preload word 0x0001_0010..1C = A0,A1,A2,A3; D_rreq with D_addr=0x0001_0018, arlenone=0, RD_LAT=2 → D_wait=0 at T+2..T+5 with D_out A0,A1,A2,A3; D_wait=1 otherwise.
2. arlenone=1, D_addr=0x0001_0014, word=0xDEADBEEF → single beat at T+2 with D_out=0xDEADBEEF; back to IDLE at T+3; D_rreq held high through T+4 does not retrigger.
3. Word 0x0001_0020=0x11223344; BYTE write D_in=0x00AB0000 at addr 0x...22 → ack at T+1; readback 0x11AB3344. Then HWORD D_in=0x0000CDEF at 0x...20 → readback 0x11ABCDEF.
4. D_rreq and D_wreq both rise at once → write is performed (WACK); no read beats occur.
5. Read D_addr=0x0000_0100 (out of range) → one beat with D_out=0 and err_o=1; write to 0x0002_0000 → ack with err_o=1 and memory unchanged.
6. Assert rst in RBEAT after beat 1 → next cycle D_wait=1, D_out=0, state IDLE. A new request after one low cycle completes normally with the preloaded data intact.
